// File: rtl/xunit_msched_if.sv
// rtl/xunit_msched_if.sv - bus bundle between the message source/round unit and xunit_msched
interface xunit_msched_if #(
  parameter int DATA_W  = 64,
  parameter int DELAY_W = 8
);
  logic               run;
  logic               done;
  logic [DATA_W-1:0]  in0;
  logic [DATA_W-1:0]  out0;
  logic               out0_valid;
  logic [DELAY_W-1:0] configDelay;
  logic               configMode;
  logic [6:0]         configRounds;

  modport master (
    output run, in0, configDelay, configMode, configRounds,
    input  done, out0, out0_valid
  );

  modport slave (
    input  run, in0, configDelay, configMode, configRounds,
    output done, out0, out0_valid
  );
endinterface

// File: rtl/xunit_msched.sv
// rtl/xunit_msched.sv - SHA-256/SHA-512 message schedule unit
// Loads 16 words, then expands W[16..R-1] through a 16-deep shift window.
module xunit_msched #(
  parameter int DATA_W  = 64,
  parameter int DELAY_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  xunit_msched_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LOAD, S_EXPAND} state_t;

  localparam logic [DATA_W-1:0] MASK32 = DATA_W'(64'h0000_0000_FFFF_FFFF);

  state_t             r_state;
  state_t             w_next;
  logic [DELAY_W-1:0] r_dly;
  logic [6:0]         r_t;
  logic [6:0]         r_rounds;
  logic               r_mode;
  logic [DATA_W-1:0]  r_w [16];
  logic [DATA_W-1:0]  r_out0;
  logic               r_valid;

  logic [6:0]         w_rounds;
  logic               w_mode;
  logic [DATA_W-1:0]  w_in;
  logic [DATA_W-1:0]  w_val;
  logic [DATA_W-1:0]  w_word;
  logic               w_shift;
  logic               w_done;

  function automatic logic [63:0] f_ext(input logic [DATA_W-1:0] x);
    logic [63:0] r;
    r = '0;
    r[DATA_W-1:0] = x;
    return r;
  endfunction

  function automatic logic [31:0] f_s0_256(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] f_s1_256(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [63:0] f_s0_512(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction

  function automatic logic [63:0] f_s1_512(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  // Round count is clamped to the legal 16..80 range at sample time.
  always_comb begin
    w_rounds = bus.configRounds;
    if (bus.configRounds < 7'd16)
      w_rounds = 7'd16;
    else if (bus.configRounds > 7'd80)
      w_rounds = 7'd80;
  end

  assign w_mode = (DATA_W == 64) ? bus.configMode : 1'b0;
  assign w_in   = r_mode ? bus.in0 : (bus.in0 & MASK32);

  always_comb begin
    logic [63:0] a0, a1, a9, a14, v;
    a0  = f_ext(r_w[0]);
    a1  = f_ext(r_w[1]);
    a9  = f_ext(r_w[9]);
    a14 = f_ext(r_w[14]);
    if (r_mode)
      v = f_s1_512(a14) + a9 + f_s0_512(a1) + a0;
    else
      v = {32'h0, f_s1_256(a14[31:0]) + a9[31:0] + f_s0_256(a1[31:0]) + a0[31:0]};
    w_val = v[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // run overrides everything, including an in-flight message.
  always_comb begin
    w_next = r_state;
    if (bus.run) begin
      w_next = (bus.configDelay == '0) ? S_LOAD : S_WAIT;
    end else begin
      case (r_state)
        S_WAIT:   if (r_dly == '0) w_next = S_LOAD;
        S_LOAD:   if (r_t == 7'd15) w_next = (r_rounds == 7'd16) ? S_IDLE : S_EXPAND;
        S_EXPAND: if (r_t == r_rounds - 7'd1) w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_shift = 1'b0;
    w_word  = w_val;
    w_done  = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_shift = !bus.run;
        w_word  = w_in;
      end
      S_EXPAND: w_shift = !bus.run;
      S_IDLE:   w_done  = !r_valid;
      default:  w_shift = 1'b0;
    endcase
  end

  // The window is deliberately not cleared on restart: LOAD rewrites all 16 slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dly    <= '0;
      r_t      <= '0;
      r_rounds <= 7'd16;
      r_mode   <= 1'b0;
      r_out0   <= '0;
      r_valid  <= 1'b0;
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
    end else begin
      r_valid <= w_shift;
      if (bus.run) begin
        r_dly    <= bus.configDelay - DELAY_W'(1);
        r_t      <= '0;
        r_rounds <= w_rounds;
        r_mode   <= w_mode;
      end else if (r_state == S_WAIT && r_dly != '0) begin
        r_dly <= r_dly - DELAY_W'(1);
      end
      if (w_shift) begin
        for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
        r_w[15] <= w_word;
        r_out0  <= w_word;
        r_t     <= r_t + 7'd1;
      end
    end
  end

  assign bus.out0       = r_out0;
  assign bus.out0_valid = r_valid;
  assign bus.done       = w_done;

endmodule

// File: tb/tb_xunit_msched.sv
// tb/tb_xunit_msched.sv - scoreboard bench for xunit_msched (64-bit and 32-bit instances)
module tb_xunit_msched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xunit_msched_if #(.DATA_W(64), .DELAY_W(8)) b64 ();
  xunit_msched_if #(.DATA_W(32), .DELAY_W(8)) b32 ();

  assign b32.run          = b64.run;
  assign b32.in0          = b64.in0[31:0];
  assign b32.configDelay  = b64.configDelay;
  assign b32.configMode   = b64.configMode;
  assign b32.configRounds = b64.configRounds;

  xunit_msched #(.DATA_W(64), .DELAY_W(8)) u64 (.clk(clk), .rst(rst), .bus(b64));
  xunit_msched #(.DATA_W(32), .DELAY_W(8)) u32 (.clk(clk), .rst(rst), .bus(b32));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int c0 = 0;
  int vc64, vc32, fv64, fv32;
  logic [63:0] q64[$];
  logic [31:0] q32[$];
  logic [63:0] exp_w[80];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rot(input logic [63:0] x, input int n, input int wd);
    logic [63:0] m;
    m = (wd == 32) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    x = x & m;
    return ((x >> n) | (x << (wd - n))) & m;
  endfunction

  // Reference: standard SHA-2 recurrence on a flat array of words.
  function automatic int clamp_r(input int r);
    return (r < 16) ? 16 : ((r > 80) ? 80 : r);
  endfunction

  task automatic model(input bit mode, input int r, input logic [63:0] m [16]);
    logic [63:0] msk, s0, s1, a, b;
    msk = mode ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    for (int t = 0; t < 80; t++) begin
      if (t < 16) begin
        exp_w[t] = m[t] & msk;
      end else begin
        a = exp_w[t-15];
        b = exp_w[t-2];
        if (mode) begin
          s0 = rot(a, 1, 64) ^ rot(a, 8, 64) ^ (a >> 7);
          s1 = rot(b, 19, 64) ^ rot(b, 61, 64) ^ (b >> 6);
        end else begin
          s0 = rot(a, 7, 32) ^ rot(a, 18, 32) ^ (a >> 3);
          s1 = rot(b, 17, 32) ^ rot(b, 19, 32) ^ (b >> 10);
        end
        exp_w[t] = (s1 + exp_w[t-7] + s0 + exp_w[t-16]) & msk;
      end
    end
    if (r > 80) r = 80;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (b64.out0_valid) begin
        if (q64.size() == 0) begin
          n_chk++;
          $display("FAIL w64_extra: got %h expected no output (cycle %0d)", b64.out0, cyc);
        end else check("w64", b64.out0, q64.pop_front());
        vc64++;
        if (fv64 < 0) fv64 = cyc - c0;
      end
      if (b32.out0_valid) begin
        if (q32.size() == 0) begin
          n_chk++;
          $display("FAIL w32_extra: got %h expected no output (cycle %0d)", b32.out0, cyc);
        end else check("w32", {32'h0, b32.out0}, {32'h0, q32.pop_front()});
        vc32++;
        if (fv32 < 0) fv32 = cyc - c0;
      end
    end
  end

  // Issues one message; nload < 16 abandons it after that many loaded words.
  task automatic run_msg(input bit mode, input int dly, input int rounds,
                         input logic [63:0] m [16], input int nload);
    int r, dc;
    r = clamp_r(rounds);
    step();
    c0 = cyc;
    b64.run          = 1'b1;
    b64.configDelay  = 8'(dly);
    b64.configMode   = mode;
    b64.configRounds = 7'(rounds);
    b64.in0          = {$urandom, $urandom};
    step();
    b64.run          = 1'b0;
    b64.configDelay  = 8'($urandom);
    b64.configMode   = 1'($urandom);
    b64.configRounds = 7'($urandom);
    q64.delete();
    q32.delete();
    vc64 = 0; vc32 = 0; fv64 = -1; fv32 = -1;
    model(1'b0, r, m);
    for (int t = 0; t < r; t++) q32.push_back(exp_w[t][31:0]);
    model(mode, r, m);
    for (int t = 0; t < r; t++) q64.push_back(exp_w[t]);
    check("done_low_after_run", {62'h0, b64.done, b32.done}, 64'h0);
    for (int k = 1; k <= dly + nload; k++) begin
      if (k > 1) step();
      b64.in0 = (k > dly) ? m[k-dly-1] : {$urandom, $urandom};
    end
    if (nload < 16) return;
    dc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (b64.done && b32.done) begin
        dc = cyc - c0;
        break;
      end
    end
    check("done_cycle", 64'(dc), 64'(dly + r + 2));
    check("valid_count64", 64'(vc64), 64'(r));
    check("valid_count32", 64'(vc32), 64'(r));
    check("first_valid_latency", 64'(fv64), 64'(dly + 2));
    check("queue_drained", 64'(q64.size() + q32.size()), 64'h0);
  endtask

  task automatic rand_msg(output logic [63:0] m [16]);
    for (int i = 0; i < 16; i++) m[i] = {$urandom, $urandom};
  endtask

  logic [63:0] msg [16];

  initial begin
    b64.run = 1'b0;
    b64.in0 = '0;
    b64.configDelay = '0;
    b64.configMode = 1'b0;
    b64.configRounds = 7'd16;
    vc64 = 0; vc32 = 0; fv64 = -1; fv32 = -1;
    repeat (2) step();
    check("rst_out0", b64.out0, 64'h0);
    check("rst_flags", {61'h0, b64.out0_valid, b64.done, b32.done}, 64'h3);
    step();
    rst = 1'b0;
    step();
    check("idle_flags", {61'h0, b64.out0_valid, b64.done, b32.done}, 64'h3);

    for (int i = 0; i < 16; i++) msg[i] = '0;
    msg[0] = 64'h6162_6380;
    msg[15] = 64'h18;
    run_msg(1'b0, 3, 64, msg, 16);
    run_msg(1'b1, 1, 64, msg, 16);

    msg[0] = 64'h6162_6380_0000_0000;
    run_msg(1'b1, 2, 80, msg, 16);

    rand_msg(msg);
    run_msg(1'b0, 0, 16, msg, 16);
    run_msg(1'b1, 0, 16, msg, 16);

    rand_msg(msg);
    run_msg(1'b1, 2, 40, msg, 7);
    rand_msg(msg);
    run_msg(1'b1, 2, 40, msg, 16);

    rand_msg(msg);
    run_msg(1'b0, 1, 5, msg, 16);
    run_msg(1'b1, 0, 100, msg, 16);

    rand_msg(msg);
    run_msg(1'b1, 0, 50, msg, 16);
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out0", b64.out0, 64'h0);
    check("async_rst_out0_32", {32'h0, b32.out0}, 64'h0);
    check("async_rst_flags", {60'h0, b64.out0_valid, b32.out0_valid, b64.done, b32.done}, 64'h3);
    q64.delete();
    q32.delete();
    step();
    rst = 1'b0;
    rand_msg(msg);
    run_msg(1'b0, 0, 20, msg, 16);

    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 3)) step();
      rand_msg(msg);
      run_msg(1'($urandom), $urandom_range(0, 6), $urandom_range(0, 127), msg, 16);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
